// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_NREG    = 4;
    localparam int DEF_AW      = 2;
    localparam int DEF_IW      = 2;
    localparam int DEF_MAXLOCK = 8;

    // Sized for the largest supported requester count (8).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = DEF_IW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    // Walk from the farthest offset down so the nearest request overwrites last.
    // NREQ is a power of two, so IW-bit addition wraps modulo NREQ for free.
    always_comb begin
        win = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[ptr + IW'(off)]) begin
                win                  = '0;
                win[ptr + IW'(off)]  = 1'b1;
            end
        end
        win_idx = IW'(onehot_to_idx(8'(win)));
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing a register bank among requesters, with bounded lock bursts.
module reg_write_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int NREG    = DEF_NREG,
    parameter int AW      = DEF_AW,
    parameter int IW      = DEF_IW,
    parameter int MAXLOCK = DEF_MAXLOCK
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREG-1:0]   reg_ena,
    output logic [W-1:0]      reg_d,
    output logic [IW-1:0]     owner,
    output logic              locked,
    output logic              err
);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            lock_pend, lock_pend_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [NREG-1:0] ena_nxt;
    logic [W-1:0]    d_nxt;
    logic [IW-1:0]   owner_nxt;
    logic            locked_nxt, err_nxt;

    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            do_arb, wr;
    logic [IW-1:0]   sel;
    logic [AW-1:0]   sel_addr;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        lock_pend_nxt = 1'b0;
        gnt_nxt       = '0;
        ena_nxt       = '0;
        d_nxt         = reg_d;
        owner_nxt     = owner;
        locked_nxt    = 1'b0;
        err_nxt       = 1'b0;
        do_arb        = 1'b0;
        wr            = 1'b0;
        sel           = owner;
        sel_addr      = '0;

        case (state)
            ST_IDLE: do_arb = 1'b1;
            ST_GRANT: begin
                if (lock_pend && MAXLOCK > 1) begin
                    state_nxt  = ST_LOCKED;
                    cnt_nxt    = 8'd1;
                    locked_nxt = 1'b1;
                    wr         = req[owner];
                end else begin
                    do_arb = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!lock[owner] || cnt >= 8'(MAXLOCK)) begin
                    do_arb = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 8'd1;
                    locked_nxt = 1'b1;
                    wr         = req[owner];
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // ptr already sits at owner+1 on lock exit, so the owner cannot jump the queue.
        if (do_arb) begin
            if (|req) begin
                state_nxt     = ST_GRANT;
                wr            = 1'b1;
                sel           = pick_idx;
                ptr_nxt       = pick_idx + IW'(1);
                owner_nxt     = pick_idx;
                lock_pend_nxt = lock[pick_idx];
            end else begin
                state_nxt = ST_IDLE;
            end
        end

        if (wr) begin
            gnt_nxt[sel] = 1'b1;
            d_nxt        = wdata[sel*W +: W];
            sel_addr     = addr[sel*AW +: AW];
            for (int j = 0; j < NREG; j++) begin
                if (32'(sel_addr) == j) ena_nxt[j] = 1'b1;
            end
            err_nxt = (32'(sel_addr) >= NREG);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            lock_pend <= 1'b0;
            gnt       <= '0;
            reg_ena   <= '0;
            reg_d     <= '0;
            owner     <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            lock_pend <= lock_pend_nxt;
            gnt       <= gnt_nxt;
            reg_ena   <= ena_nxt;
            reg_d     <= d_nxt;
            owner     <= owner_nxt;
            locked    <= locked_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: directed literal checks plus randomized traffic against a behavioural model.
module tb_reg_write_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int NREG    = 3;
    localparam int AW      = 2;
    localparam int IW      = 2;
    localparam int MAXLOCK = 8;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREG-1:0]   reg_ena;
    logic [W-1:0]      reg_d;
    logic [IW-1:0]     owner;
    logic              locked;
    logic              err;

    int n_vec = 0;
    int n_err = 0;

    reg_write_arbiter #(
        .NREQ(NREQ), .W(W), .NREG(NREG), .AW(AW), .IW(IW), .MAXLOCK(MAXLOCK)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .reg_ena (reg_ena),
        .reg_d   (reg_d),
        .owner   (owner),
        .locked  (locked),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr = 0;
    int          m_owner = 0;
    int          m_age = 0;
    bit          m_in_lock = 0;
    bit          m_lock_next = 0;
    logic [3:0]  e_gnt = '0;
    logic [2:0]  e_ena = '0;
    logic [7:0]  e_d = '0;
    logic        e_locked = 1'b0;
    logic        e_err = 1'b0;

    task automatic m_write(input int i);
        int a;
        a     = int'(addr[i*AW +: AW]);
        e_gnt = 4'(1 << i);
        e_d   = wdata[i*W +: W];
        if (a < NREG) e_ena = 3'(1 << a);
        else          e_err = 1'b1;
    endtask

    task automatic m_arbitrate();
        m_lock_next = 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i]) begin
                m_write(i);
                m_owner     = i;
                m_ptr       = (i + 1) % NREQ;
                m_lock_next = lock[i];
                break;
            end
        end
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_ptr = 0; m_owner = 0; m_age = 0; m_in_lock = 0; m_lock_next = 0;
            e_gnt = '0; e_ena = '0; e_d = '0; e_locked = 1'b0; e_err = 1'b0;
        end else begin
            e_gnt = '0; e_ena = '0; e_err = 1'b0; e_locked = 1'b0;
            if (m_in_lock) begin
                if (!lock[m_owner] || m_age == MAXLOCK) begin
                    m_in_lock = 0;
                    m_arbitrate();
                end else begin
                    m_age++;
                    e_locked = 1'b1;
                    if (req[m_owner]) m_write(m_owner);
                end
            end else if (m_lock_next && MAXLOCK > 1) begin
                m_lock_next = 0;
                m_in_lock   = 1;
                m_age       = 1;
                e_locked    = 1'b1;
                if (req[m_owner]) m_write(m_owner);
            end else begin
                m_arbitrate();
            end
        end
    end

    // Single compare process: every falling edge, DUT against model (or reset zeros).
    always @(negedge clock) begin
        if (!reset) begin
            check("rst_gnt", 32'(gnt), 0);
            check("rst_ena", 32'(reg_ena), 0);
            check("rst_d", 32'(reg_d), 0);
            check("rst_owner", 32'(owner), 0);
            check("rst_locked", 32'(locked), 0);
            check("rst_err", 32'(err), 0);
        end else begin
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("reg_ena", 32'(reg_ena), 32'(e_ena));
            check("reg_d", 32'(reg_d), 32'(e_d));
            check("owner", 32'(owner), 32'(m_owner));
            check("locked", 32'(locked), 32'(e_locked));
            check("err", 32'(err), 32'(e_err));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        req   = 4'b1111;
        lock  = '0;
        addr  = '0;
        wdata = '0;

        // Reset held with all requests pending.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("hold_gnt", 32'(gnt), 0);
            check("hold_ena", 32'(reg_ena), 0);
            check("hold_owner", 32'(owner), 0);
            check("hold_locked", 32'(locked), 0);
        end
        reset = 1'b1;

        // Fairness with no idle cycles.
        @(negedge clock); check("fair0", 32'(gnt), 32'h1);
        @(negedge clock); check("fair1", 32'(gnt), 32'h2);
        @(negedge clock); check("fair2", 32'(gnt), 32'h4);
        @(negedge clock); check("fair3", 32'(gnt), 32'h8);
        @(negedge clock); check("fair4", 32'(gnt), 32'h1);
        req = '0;
        @(negedge clock); check("fair_idle", 32'(gnt), 0);

        // Single write to register 2.
        req = 4'b0001; addr[0 +: AW] = 2'd2; wdata[0 +: W] = 8'hA5;
        @(negedge clock);
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_ena", 32'(reg_ena), 32'h4);
        check("single_d", 32'(reg_d), 32'hA5);
        req = '0;
        @(negedge clock);
        check("single_idle", 32'(gnt), 0);
        check("single_hold_d", 32'(reg_d), 32'hA5);

        // Out-of-range address (NREG = 3).
        req = 4'b1000; addr[3*AW +: AW] = 2'd3;
        @(negedge clock);
        check("bad_gnt", 32'(gnt), 32'h8);
        check("bad_ena", 32'(reg_ena), 0);
        check("bad_err", 32'(err), 1);
        req = '0;
        @(negedge clock);
        check("bad_err_pulse", 32'(err), 0);

        // Lock burst bounded by MAXLOCK.
        req = 4'b0110; lock = 4'b0010;
        @(negedge clock);
        check("lk_grant", 32'(gnt), 32'h2);
        check("lk_grant_locked", 32'(locked), 0);
        for (int c = 0; c < MAXLOCK; c++) begin
            @(negedge clock);
            check("lk_burst_gnt", 32'(gnt), 32'h2);
            check("lk_burst_locked", 32'(locked), 1);
        end
        @(negedge clock);
        check("lk_next_gnt", 32'(gnt), 32'h4);
        check("lk_exit_locked", 32'(locked), 0);
        req = '0; lock = '0;
        @(negedge clock);
        check("lk_idle", 32'(gnt), 0);

        // Reset in the middle of a lock.
        req = 4'b0010; lock = 4'b0010;
        @(negedge clock); check("ml_grant", 32'(gnt), 32'h2);
        @(negedge clock); check("ml_locked", 32'(locked), 1);
        #2 reset = 1'b0;
        #1;
        check("ml_async_locked", 32'(locked), 0);
        check("ml_async_gnt", 32'(gnt), 0);
        check("ml_async_ena", 32'(reg_ena), 0);
        req = 4'b1011; lock = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ml_first_gnt", 32'(gnt), 32'h1);
        check("ml_first_owner", 32'(owner), 0);

        // Randomized traffic: light locking, then heavy locking.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset = 1'b1;
            req   = 4'($urandom);
            if (c < 1500) lock = 4'($urandom) & 4'($urandom) & 4'($urandom);
            else          lock = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
            addr  = 8'($urandom);
            wdata = 32'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
            end
        end
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
